// File: rtl/countdown_timer_pkg.sv
// Types and constants shared by the countdown timer top and its channels.
`include "timer_defs.vh"

package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `ST_IDLE,
    ST_RUN    = `ST_RUN,
    ST_EXPIRE = `ST_EXPIRE
  } timer_state_t;

  localparam int NUM_CH  = 2;
  localparam int PRESC_W = 4;

endpackage

// File: rtl/countdown_timer_channel.sv
// One down-counting channel: load/run/expire FSM plus its value register.
`include "timer_defs.vh"

module timer_channel
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] remain,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_reg, state_next;
  logic [WIDTH-1:0] remain_reg, remain_next;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= ST_IDLE;
      remain_reg <= `TIMER_ZERO;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
    end
  end

  // Load has priority over a tick in every state; a zero load parks the channel.
  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    if (load) begin
      remain_next = load_value;
      state_next  = (load_value != `TIMER_ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (tick) begin
            remain_next = remain_reg - WIDTH'(1);
            if (remain_reg == WIDTH'(1)) state_next = ST_EXPIRE;
          end
        end
        ST_EXPIRE: state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  assign remain = remain_reg;
  assign busy   = (state_reg == ST_RUN);
  assign done   = (state_reg == ST_EXPIRE);

endmodule

// File: rtl/timer_defs.vh
// Shared state encodings and the all-zero counter value for the countdown timer.
`ifndef TIMER_DEFS_VH
`define TIMER_DEFS_VH
`define ST_IDLE     2'd0
`define ST_RUN      2'd1
`define ST_EXPIRE   2'd2
`define TIMER_ZERO  {WIDTH{1'b0}}
`endif

// File: rtl/countdown_timer.sv
// Two-channel countdown timer: channel 0 ticks every enabled cycle, channel 1 every PRESCALE.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Slt,
  input  logic             Load,
  input  logic             LoadSel,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Remain0,
  output logic [WIDTH-1:0] Remain1,
  output logic             Busy0,
  output logic             Busy1,
  output logic             Done0,
  output logic             Done1
);

  logic [NUM_CH-1:0] tick, load, busy, done;
  logic [WIDTH-1:0]  remain [NUM_CH];
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic               presc_wrap;
  logic               ch1_advance;

  assign ch1_advance = En && Slt && busy[1];
  assign presc_wrap  = (presc_reg == PRESC_W'(PRESCALE - 1));

  // Any load to channel 1 restarts its divider so a fresh count gets full periods.
  always_comb begin
    presc_next = presc_reg;
    if (load[1])          presc_next = '0;
    else if (ch1_advance) presc_next = presc_wrap ? '0 : presc_reg + PRESC_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) presc_reg <= '0;
    else        presc_reg <= presc_next;
  end

  assign tick[0] = En && !Slt;
  assign tick[1] = ch1_advance && presc_wrap;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load[gi] = Load && (LoadSel == 1'(gi));

      timer_channel #(.WIDTH(WIDTH)) u_channel (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (tick[gi]),
        .load       (load[gi]),
        .load_value (LoadValue),
        .remain     (remain[gi]),
        .busy       (busy[gi]),
        .done       (done[gi])
      );
    end
  endgenerate

  assign Remain0 = remain[0];
  assign Remain1 = remain[1];
  assign Busy0   = busy[0];
  assign Busy1   = busy[1];
  assign Done0   = done[0];
  assign Done1   = done[1];

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed checks of countdown_timer against a flag-based reference model.
module tb_countdown_timer;
  localparam int W = 64;
  localparam int PRESCALE = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0, Slt = 1'b0, Load = 1'b0, LoadSel = 1'b0;
  logic [W-1:0] LoadValue = '0;
  logic [W-1:0] Remain0, Remain1;
  logic         Busy0, Busy1, Done0, Done1;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(W), .PRESCALE(PRESCALE)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Load(Load), .LoadSel(LoadSel),
    .LoadValue(LoadValue), .Remain0(Remain0), .Remain1(Remain1),
    .Busy0(Busy0), .Busy1(Busy1), .Done0(Done0), .Done1(Done1)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: value, running flag, just-expired flag, divider count.
  logic [W-1:0] m_rem [2];
  bit           m_run [2];
  bit           m_done[2];
  int           m_pre;
  bit           m_ld  [2];
  bit           m_fire[2];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int c = 0; c < 2; c++) begin
        m_rem[c] = '0; m_run[c] = 0; m_done[c] = 0;
      end
      m_pre = 0;
    end else begin
      m_ld[0] = Load && !LoadSel;
      m_ld[1] = Load && LoadSel;
      m_fire[0] = En && !Slt;
      m_fire[1] = 0;
      if (m_ld[1]) m_pre = 0;
      else if (m_run[1] && En && Slt) begin
        if (m_pre + 1 == PRESCALE) begin
          m_pre = 0;
          m_fire[1] = 1;
        end else m_pre = m_pre + 1;
      end
      for (int c = 0; c < 2; c++) begin
        m_done[c] = 0;
        if (m_ld[c]) begin
          m_rem[c] = LoadValue;
          m_run[c] = (LoadValue != 0);
        end else if (m_run[c] && m_fire[c]) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_run[c]  = 0;
            m_done[c] = 1;
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    check("model_remain0", Remain0, m_rem[0]);
    check("model_remain1", Remain1, m_rem[1]);
    check("model_busy0",   W'(Busy0), W'(m_run[0]));
    check("model_busy1",   W'(Busy1), W'(m_run[1]));
    check("model_done0",   W'(Done0), W'(m_done[0]));
    check("model_done1",   W'(Done1), W'(m_done[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_load(input logic sel, input logic [W-1:0] val);
    Load = 1'b1; LoadSel = sel; LoadValue = val;
    cyc(1);
    Load = 1'b0;
  endtask

  logic [W-1:0] all_f;

  initial begin
    all_f = '1;
    cyc(3);
    check("reset_remain0", Remain0, '0);
    check("reset_busy1",   W'(Busy1), '0);
    Reset = 1'b1;
    cyc(1);

    // Channel 0 counts 3,2,1,0 then pulses Done0.
    En = 1'b0;
    do_load(1'b0, 64'd3);
    check("t2_load", Remain0, 64'd3);
    check("t2_busy", W'(Busy0), 1);
    En = 1'b1; Slt = 1'b0;
    cyc(1); check("t2_r2", Remain0, 64'd2);
    cyc(1); check("t2_r1", Remain0, 64'd1);
    cyc(1); check("t2_r0", Remain0, 64'd0);
    check("t2_done", W'(Done0), 1);
    check("t2_busy_fall", W'(Busy0), 0);
    cyc(1); check("t2_done_clear", W'(Done0), 0);
    check("t2_no_wrap", Remain0, 64'd0);

    // Channel 1 ticks on every fourth enabled cycle.
    En = 1'b0;
    do_load(1'b1, 64'd2);
    En = 1'b1; Slt = 1'b1;
    cyc(3); check("t3_hold", Remain1, 64'd2);
    cyc(1); check("t3_tick1", Remain1, 64'd1);
    cyc(3); check("t3_hold2", Remain1, 64'd1);
    cyc(1); check("t3_zero", Remain1, 64'd0);
    check("t3_done1", W'(Done1), 1);
    check("t3_ch0_untouched", Remain0, 64'd0);
    cyc(1); check("t3_done1_clear", W'(Done1), 0);

    // Divider freezes when En is low or Slt points at channel 0.
    En = 1'b0;
    do_load(1'b1, 64'd3);
    En = 1'b1; Slt = 1'b1;
    cyc(2);
    En = 1'b0; cyc(3);
    En = 1'b1; Slt = 1'b0; cyc(3);
    check("t4_frozen", Remain1, 64'd3);
    Slt = 1'b1;
    cyc(1); check("t4_third", Remain1, 64'd3);
    cyc(1); check("t4_tick", Remain1, 64'd2);

    // Zero load stays idle; load beats a terminal tick.
    En = 1'b0;
    do_load(1'b0, 64'd0);
    check("t5_zero_busy", W'(Busy0), 0);
    cyc(1); check("t5_zero_done", W'(Done0), 0);
    do_load(1'b0, 64'd2);
    En = 1'b1; Slt = 1'b0;
    cyc(1); check("t5_at_one", Remain0, 64'd1);
    do_load(1'b0, 64'd7);
    check("t5_reload", Remain0, 64'd7);
    check("t5_no_done", W'(Done0), 0);
    check("t5_busy", W'(Busy0), 1);

    // Full-scale start value decrements without wrap.
    En = 1'b0;
    do_load(1'b1, all_f);
    En = 1'b1; Slt = 1'b1;
    cyc(3); check("t6_hold", Remain1, all_f);
    cyc(1); check("t6_fffe", Remain1, all_f - 64'd1);

    // Asynchronous reset in the middle of a count.
    En = 1'b0;
    do_load(1'b0, 64'd5);
    check("t1_loaded", Remain0, 64'd5);
    #2 Reset = 1'b0;
    #1;
    check("t1_async_remain0", Remain0, '0);
    check("t1_async_busy0",   W'(Busy0), 0);
    check("t1_async_remain1", Remain1, '0);
    cyc(2);
    Reset = 1'b1;
    En = 1'b1; Slt = 1'b0;
    cyc(3);
    check("t1_stay_zero", Remain0, '0);
    check("t1_stay_idle", W'(Busy0), 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      En      = ($urandom_range(0, 9) < 8);
      Slt     = $urandom_range(0, 1);
      Load    = ($urandom_range(0, 11) == 0);
      LoadSel = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       LoadValue = '0;
        1:       LoadValue = {$urandom, $urandom};
        default: LoadValue = W'($urandom_range(1, 12));
      endcase
      if ($urandom_range(0, 599) == 0) begin
        #2 Reset = 1'b0;
        cyc(1);
        Reset = 1'b1;
      end else begin
        cyc(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
